// File: rtl/vga_pkg.sv
// Shared timing constants, mode encodings and colour-bar table for the VGA scan controller.
// Pure declarations: no latency, no backpressure.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // {R,G,B} on/off per bar, index 0 is the leftmost (white ... black)
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    typedef struct packed {
        mode_e      mode;
        logic       first;
        logic       active;
        logic       hsync;
        logic       vsync;
        logic [9:0] h;
        logic [9:0] v;
    } pipe_t;

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Pixel-source request bus: column/row address plus read enable.
// Purely combinational wiring; the source has no way to stall the scan.
interface vga_scan_ctrl_if;
    logic [9:0] h_addr;
    logic [9:0] v_addr;
    logic       rd_en;

    modport master (output h_addr, output v_addr, output rd_en);
    modport slave  (input  h_addr, input  v_addr, input  rd_en);
endinterface

// File: rtl/vga_delay_line.sv
// pix_ce-gated shift register of DEPTH stages; DEPTH=0 is a wire.
// Latency DEPTH enabled ticks; holds while ce=0, no backpressure.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ok;
            assign unused_ok = ^{clk, reset, ce};
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
                if (ce) begin
                    stage_d[0] = din;
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_ctrl_timing.sv
// Horizontal/vertical scan counters with raw active/sync decode and source address bus.
// Decode is combinational from the counters; advances only on pix_ce, never stalls.
module vga_scan_ctrl_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_ce,
    vga_scan_ctrl_if.master  src,
    output logic [9:0]       h_cnt,
    output logic [9:0]       v_cnt,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             first
);

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt  = h_cnt_q;
    assign v_cnt  = v_cnt_q;
    assign active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hsync  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vsync  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    assign first  = (h_cnt_q == '0) && (v_cnt_q == '0);

    assign src.h_addr = active ? h_cnt_q : '0;
    assign src.v_addr = active ? v_cnt_q : '0;
    assign src.rd_en  = active;

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: timing, source-aligned delay line, pattern mux and output registers.
// Pins lag the counters by RD_LAT+1 pix_ce ticks; runs free, no backpressure.
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 8,
    parameter int RD_LAT   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pix_ce,
    input  logic [1:0]      mode,
    input  logic [3*CW-1:0] solid_rgb,
    input  logic [3*CW-1:0] pix_rgb,
    output logic [9:0]      h_addr,
    output logic [9:0]      v_addr,
    output logic            rd_en,
    output logic [CW-1:0]   vga_r,
    output logic [CW-1:0]   vga_g,
    output logic [CW-1:0]   vga_b,
    output logic            vga_hs,
    output logic            vga_vs,
    output logic            vga_blank_n,
    output logic            frame_start
);

    localparam logic       HS_ON = 1'(HS_POL);
    localparam logic       VS_ON = 1'(VS_POL);
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

    vga_scan_ctrl_if src_if ();

    logic [9:0] h_cnt, v_cnt;
    logic       raw_active, raw_hs, raw_vs, raw_first;

    vga_scan_ctrl_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .pix_ce (pix_ce),
        .src    (src_if),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (raw_active),
        .hsync  (raw_hs),
        .vsync  (raw_vs),
        .first  (raw_first)
    );

    assign h_addr = src_if.h_addr;
    assign v_addr = src_if.v_addr;
    assign rd_en  = src_if.rd_en;

    // The frame's mode rides with its pixels so it lines up at any RD_LAT, including 0.
    mode_e mode_q, mode_d, cur_mode;
    assign cur_mode = raw_first ? mode_e'(mode) : mode_q;
    assign mode_d   = pix_ce ? cur_mode : mode_q;

    pipe_t pipe_in, pipe_out;
    assign pipe_in = '{mode: cur_mode, first: raw_first, active: raw_active,
                       hsync: raw_hs, vsync: raw_vs, h: h_cnt, v: v_cnt};

    vga_delay_line #(.WIDTH($bits(pipe_t)), .DEPTH(RD_LAT)) u_dly (
        .clk   (clk),
        .reset (reset),
        .ce    (pix_ce),
        .din   (pipe_in),
        .dout  (pipe_out)
    );

    logic unused_v;
    assign unused_v = ^{pipe_out.v[9:6], pipe_out.v[4:0]};

    logic [3*CW-1:0] pat_rgb;
    logic [9:0]      bar_idx;
    logic [2:0]      bar_flags;
    logic [3*CW-1:0] rgb_q, rgb_d;
    logic            hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d, fs_q, fs_d;

    always_comb begin
        bar_idx   = pipe_out.h / BAR_W;
        bar_flags = BAR_RGB[(bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0]];
        pat_rgb   = '0;
        case (pipe_out.mode)
            MODE_EXT:   pat_rgb = pix_rgb;
            MODE_BARS:  pat_rgb = {{CW{bar_flags[2]}}, {CW{bar_flags[1]}}, {CW{bar_flags[0]}}};
            MODE_CHECK: pat_rgb = (pipe_out.h[5] ^ pipe_out.v[5]) ? '0 : '1;
            MODE_SOLID: pat_rgb = solid_rgb;
            default:    pat_rgb = '0;
        endcase
    end

    // frame_start is a single-clk strobe, so it drops on idle clocks instead of holding.
    always_comb begin
        rgb_d     = rgb_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        fs_d      = 1'b0;
        if (pix_ce) begin
            rgb_d     = pipe_out.active ? pat_rgb : '0;
            hs_d      = pipe_out.hsync ? HS_ON : ~HS_ON;
            vs_d      = pipe_out.vsync ? VS_ON : ~VS_ON;
            blank_n_d = pipe_out.active;
            fs_d      = pipe_out.first;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q     <= '0;
            hs_q      <= ~HS_ON;
            vs_q      <= ~VS_ON;
            blank_n_q <= 1'b0;
            fs_q      <= 1'b0;
            mode_q    <= MODE_EXT;
        end else begin
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            fs_q      <= fs_d;
            mode_q    <= mode_d;
        end
    end

    assign vga_r       = rgb_q[3*CW-1:2*CW];
    assign vga_g       = rgb_q[2*CW-1:CW];
    assign vga_b       = rgb_q[CW-1:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl on a 14x7 raster: RD_LAT=2 and RD_LAT=0 instances against a position-based model.
module tb_vga_scan_ctrl;
    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        fs;
    } pins_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_ce = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] solid_rgb = 12'h000;
    logic [11:0] pix_rgb, pix_rgb0;
    logic [9:0]  h_addr, v_addr, h_addr0, v_addr0;
    logic        rd_en, rd_en0;
    logic [3:0]  vr, vg, vb, vr0, vg0, vb0;
    logic        hs, vs, bn, fs, hs0, vs0, bn0, fs0;

    always #5 clk = ~clk;

    vga_scan_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CW(4), .RD_LAT(2)
    ) dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .mode(mode),
        .solid_rgb(solid_rgb), .pix_rgb(pix_rgb),
        .h_addr(h_addr), .v_addr(v_addr), .rd_en(rd_en),
        .vga_r(vr), .vga_g(vg), .vga_b(vb), .vga_hs(hs), .vga_vs(vs),
        .vga_blank_n(bn), .frame_start(fs)
    );

    vga_scan_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CW(4), .RD_LAT(0)
    ) dut0 (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .mode(mode),
        .solid_rgb(solid_rgb), .pix_rgb(pix_rgb0),
        .h_addr(h_addr0), .v_addr(v_addr0), .rd_en(rd_en0),
        .vga_r(vr0), .vga_g(vg0), .vga_b(vb0), .vga_hs(hs0), .vga_vs(vs0),
        .vga_blank_n(bn0), .frame_start(fs0)
    );

    // Pixel source: memory returning {h,v,5} two enabled ticks after the request.
    vga_scan_ctrl_if src_bus ();
    assign src_bus.h_addr = h_addr;
    assign src_bus.v_addr = v_addr;
    assign src_bus.rd_en  = rd_en;

    logic [9:0] e1_h = '0, e1_v = '0, e2_h = '0, e2_v = '0;
    always @(posedge clk) begin
        if (pix_ce) begin
            e1_h <= src_bus.h_addr;
            e1_v <= src_bus.v_addr;
            e2_h <= e1_h;
            e2_v <= e1_v;
        end
    end
    assign pix_rgb  = {e2_h[3:0], e2_v[3:0], 4'h5};
    assign pix_rgb0 = {h_addr0[3:0], v_addr0[3:0], 4'h5};

    int          checks = 0;
    int          errors = 0;
    int          k = 0;
    int          cyc = 0;
    int          last_fs = -1;
    int          exp_period = 0;
    logic [1:0]  mode_hist [0:8191];
    pins_t       exp2, exp0;
    logic [11:0] bar_tab [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, expv, k);
        end
    endtask

    function automatic logic [1:0] mode_of(input int p);
        if (p < 0) return 2'd0;
        return mode_hist[(p / FT) * FT];
    endfunction

    // Expected pins when raster position p (pixels since reset release) is on the pins.
    function automatic pins_t model(input int p, input logic [1:0] m, input logic [11:0] solid);
        pins_t e;
        int h, v;
        e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, bn: 1'b0, fs: 1'b0};
        if (p < 0) return e;
        h = p % HT;
        v = (p / HT) % VT;
        e.hs = !(h >= 10 && h < 12);
        e.vs = (v != 5);
        e.fs = (h == 0 && v == 0);
        e.bn = (h < 8 && v < 4);
        if (e.bn) begin
            case (m)
                2'd0: e.rgb = {4'(h), 4'(v), 4'h5};
                2'd1: e.rgb = bar_tab[h];
                2'd2: e.rgb = (((h / 32) % 2) != ((v / 32) % 2)) ? 12'h000 : 12'hFFF;
                default: e.rgb = solid;
            endcase
        end
        return e;
    endfunction

    task automatic tick();
        logic r, ce;
        int h, v;
        logic act;
        @(posedge clk);
        r  = reset;
        ce = pix_ce;
        cyc++;
        if (r) begin
            exp2 = model(-1, 2'd0, solid_rgb);
            exp0 = exp2;
            k = 0;
        end else if (ce) begin
            mode_hist[k] = mode;
            exp2 = model(k - 2, mode_of(k - 2), solid_rgb);
            exp0 = model(k, mode_of(k), solid_rgb);
            k++;
        end else begin
            exp2.fs = 1'b0;
            exp0.fs = 1'b0;
        end
        #1;
        chk("rgb_lat2",     {vr, vg, vb}, exp2.rgb);
        chk("hs_lat2",      hs, exp2.hs);
        chk("vs_lat2",      vs, exp2.vs);
        chk("blank_n_lat2", bn, exp2.bn);
        chk("fstart_lat2",  fs, exp2.fs);
        chk("rgb_lat0",     {vr0, vg0, vb0}, exp0.rgb);
        chk("hs_lat0",      hs0, exp0.hs);
        chk("vs_lat0",      vs0, exp0.vs);
        chk("blank_n_lat0", bn0, exp0.bn);
        chk("fstart_lat0",  fs0, exp0.fs);
        h = k % HT;
        v = (k / HT) % VT;
        act = (h < 8 && v < 4);
        chk("h_addr",  h_addr, act ? h : 0);
        chk("v_addr",  v_addr, act ? v : 0);
        chk("rd_en",   rd_en, act);
        chk("h_addr0", h_addr0, act ? h : 0);
        chk("rd_en0",  rd_en0, act);
        if (fs === 1'b1) begin
            if (last_fs >= 0 && exp_period != 0) chk("frame_period", cyc - last_fs, exp_period);
            last_fs = cyc;
        end
    endtask

    initial begin
        bar_tab = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        solid_rgb = 12'($urandom);
        exp2 = model(-1, 2'd0, solid_rgb);
        exp0 = exp2;

        // reset with and without pix_ce
        repeat (3) tick();
        pix_ce = 1'b1;
        tick();

        // free run, external source
        reset = 1'b0;
        last_fs = -1;
        exp_period = FT;
        repeat (2 * FT + 10) tick();

        // mid-frame switches: each takes effect from the following frame
        mode = 2'd1;
        repeat (2 * FT) tick();
        mode = 2'd2;
        repeat (2 * FT) tick();
        mode = 2'd3;
        repeat (2 * FT) tick();

        // pix_ce on every 4th clk
        mode = 2'd0;
        last_fs = -1;
        exp_period = 4 * FT;
        for (int i = 0; i < 3 * 4 * FT + 8; i++) begin
            pix_ce = (i % 4 == 3);
            tick();
        end

        // random enables and mode changes
        exp_period = 0;
        for (int i = 0; i < 600; i++) begin
            pix_ce = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 40) == 0) mode = 2'($urandom_range(0, 3));
            tick();
        end

        // reset mid-frame at (h=5, v=2)
        pix_ce = 1'b1;
        mode = 2'd0;
        for (int i = 0; i < 2 * FT; i++) begin
            if (k % FT == 2 * HT + 5) break;
            tick();
        end
        chk("reset_point", k % FT, 2 * HT + 5);
        last_fs = -1;
        exp_period = FT;
        reset = 1'b1;
        pix_ce = 1'b0;
        tick();
        reset = 1'b0;
        pix_ce = 1'b1;
        repeat (2) tick();
        tick();
        chk("fstart_after_reset", fs, 1'b1);
        repeat (FT + 5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
